// File: rtl/booth_pkg.sv
// Shared constants and types for the time-shared Booth multiplier.
package booth_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NREQ_DEF  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    // {q[0], q_-1} pairs that modify the accumulator
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of br into acc_hi, then
// arithmetic right shift of {acc_hi, q, q_-1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   acc_hi,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] br,
    output logic [WIDTH:0]   acc_hi_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_m1_nxt
);

    logic [WIDTH:0] br_ext;
    logic [WIDTH:0] sum;

    // One guard bit keeps br = most-negative exact without post-correction
    assign br_ext = {br[WIDTH-1], br};

    always_comb begin
        sum = acc_hi;
        case ({q[0], q_m1})
            BOOTH_ADD: sum = acc_hi + br_ext;
            BOOTH_SUB: sum = acc_hi - br_ext;
            default:   sum = acc_hi;
        endcase
    end

    assign acc_hi_nxt = {sum[WIDTH], sum[WIDTH:1]};
    assign q_nxt      = {sum[0], q[WIDTH-1:1]};
    assign q_m1_nxt   = q[0];

endmodule

// File: rtl/booth_mul_arb.sv
// Arbitrated multi-cycle Booth multiplier shared by NREQ requesters.
// Define BOOTH_MUL_ARB_RR_EN for round-robin; otherwise fixed lowest-index priority.
//
// state | meaning
// IDLE  | arbitrate, accept winner's operands
// CALC  | one Booth step per cycle, WIDTH cycles
// DONE  | product presented until rsp_ready
module booth_mul_arb
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_qr,
    input  logic [NREQ*WIDTH-1:0]    req_br,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [2*WIDTH-1:0]       rsp_prod,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH-1:0] br;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   acc_hi_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             q_m1_nxt;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   win_idx;
    logic             win_any;
    logic             accept;
    logic [NREQ-1:0]  win_onehot;

    // Walk downward so the candidate closest to the pointer is assigned last and wins
    always_comb begin
        win_any = |req_valid;
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int cand;
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (req_valid[cand]) win_idx = IDW'(cand);
        end
    end

    always_comb begin
        win_onehot = '0;
        win_onehot[win_idx] = 1'b1;
    end

    assign accept    = (state == IDLE) && win_any;
    assign req_ready = accept ? win_onehot : '0;

`ifdef BOOTH_MUL_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
        end
    end
`else
    assign rr_ptr = '0;
`endif

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_hi     (acc_hi),
        .q          (q),
        .q_m1       (q_m1),
        .br         (br),
        .acc_hi_nxt (acc_hi_nxt),
        .q_nxt      (q_nxt),
        .q_m1_nxt   (q_m1_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc_hi <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            br     <= '0;
            cnt    <= '0;
            rsp_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        q      <= req_qr[win_idx*WIDTH +: WIDTH];
                        br     <= req_br[win_idx*WIDTH +: WIDTH];
                        acc_hi <= '0;
                        q_m1   <= 1'b0;
                        cnt    <= CW'(WIDTH);
                        rsp_id <= win_idx;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc_hi <= acc_hi_nxt;
                    q      <= q_nxt;
                    q_m1   <= q_m1_nxt;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_prod  = {acc_hi[WIDTH-1:0], q};

endmodule

// File: doc/booth_mul_arb.md
# booth_mul_arb

Multi-cycle radix-2 Booth multiplier with a built-in arbiter that shares one add/shift datapath between NREQ requesters. Each accepted request performs one Booth step per clock and returns a signed 2·WIDTH-bit product tagged with the requester index. It sits between the operand producers and the consumers of the products, replacing per-requester combinational multipliers with one time-shared unit.

## Interface
- WIDTH, 4, operand width in bits; both operands are signed two's complement.
- NREQ, 2, number of requesters, 2..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  one-hot grant/accept; bit i high means requester i transfers this cycle.
- req_qr  in  NREQ·WIDTH  multipliers; requester i occupies bits [i·WIDTH +: WIDTH].
- req_br  in  NREQ·WIDTH  multiplicands, same packing as req_qr.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts the product.
- rsp_id  out  clog2(NREQ)  index of the requester that owns rsp_prod.
- rsp_prod  out  2·WIDTH  signed product qr·br.
- busy  out  1  high in CALC and DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - req_ready is driven combinationally as the one-hot arbiter winner among req_valid.
  - If any req_valid is high, the winner's operands are latched. The accumulator is cleared. The Booth bit q_-1 is set to 0. The step counter is loaded with WIDTH and rsp_id is set to the winner.
  - The state then moves to CALC.
  - With no req_valid, the block stays in IDLE and req_ready is all zero.
- CALC:
  - req_ready is all zero.
  - Each cycle examines {q[0], q_-1}: 10 subtracts br from the upper accumulator, 01 adds br, and 00/11 leave it unchanged.
  - The combined {acc_hi, q, q_-1} then shifts right arithmetically by one.
  - The counter decrements. When it reaches 0, the state moves to DONE.
- Arithmetic:
  - acc_hi is WIDTH+1 bits and br is sign-extended to WIDTH+1 before the add or subtract.
  - This makes br = most-negative (e.g. −8 at WIDTH=4) exact with no post-correction.
  - rsp_prod is the low 2·WIDTH bits of {acc_hi, q} after WIDTH steps.
- DONE:
  - rsp_valid is high. rsp_prod and rsp_id are held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready, the state moves to IDLE.
- Arbitration:
  - The round-robin pointer advances to the index after the winner on each accept.
  - Search order starts at the pointer.
- Requests not granted keep req_valid high; the block never drops a request silently.
- Requester operands only need to be stable during the accept cycle.

## Timing
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_prod 0, busy 0, round-robin pointer 0.
- Accept in cycle T (IDLE, valid&&ready):
  - CALC occupies T+1..T+WIDTH.
  - rsp_valid rises at T+WIDTH+1.
- Latency from accept to rsp_valid is WIDTH+1 cycles.
- Response handshake in cycle R: the block is in IDLE at R+1 and can accept at R+1. Best-case issue interval is WIDTH+2 cycles.
- rsp_ready held high while DONE is entered: the response completes in its first cycle.
- Simultaneous req_valid: exactly one bit of req_ready is set; the others wait.
- req_valid arriving during CALC/DONE is ignored until IDLE.
- rst_n asserted mid-CALC or mid-DONE: the in-flight product is discarded, outputs return to reset values immediately, and no response is issued after release.

## Configuration
- BOOTH_MUL_ARB_RR_EN defined: round-robin arbitration as above.
- BOOTH_MUL_ARB_RR_EN undefined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Package booth_pkg holds:
  - the state enum {IDLE, CALC, DONE};
  - the default WIDTH and NREQ constants;
  - the Booth-pair encoding constants (ADD=01, SUB=10).
- Sub-module booth_step is purely combinational, one Booth iteration: inputs acc_hi, q, q_-1, br; outputs the next acc_hi, q, q_-1.
- The arbiter stays inline.

## Test plan
- Req0 only, qr=3, br=−2, rsp_ready=1 → rsp_valid exactly 5 cycles after accept, rsp_prod=8'hFA (−6), rsp_id=0.
- Req1 only, qr=−8, br=−8 → rsp_prod=8'h40 (64); qr=7, br=−8 → 8'hC8 (−56).
- Both valid every cycle, RR enabled → grants alternate 0,1,0,1; products correct per requester; with macro undefined → req0 always wins.
- rsp_ready low for 3 cycles in DONE → rsp_valid, rsp_prod and rsp_id stable, req_ready stays 0, no new accept until the cycle after the handshake.
- rst_n pulsed low 2 cycles into CALC → all outputs 0 at once; after release the block is in IDLE and no spurious rsp_valid occurs.
- Exhaustive sweep of all 256 qr/br pairs at WIDTH=4 → every rsp_prod equals the signed reference product.
